// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Word-organised data memory that answers single read/write requests from a
// CPU controller after a fixed number of wait states. A request is sampled
// only while idle. Its operation, word address and write data are captured
// at acceptance, and later request activity cannot disturb them. The access
// completes WAIT_CYCLES+1 cycles after acceptance with a one-cycle dm_ready
// pulse. On that same edge a read updates dm_out or a write commits to the
// array.
//
// Optional feature (compile-time macro DM_ALIGN_CHECK_EN):
//   defined   : requests whose dm_address[1:0] is non-zero are rejected with
//               a dm_error pulse and no access.
//   undefined : dm_address[1:0] is ignored and the request goes to the word.
//
// Parameters
//   ADDR_WIDTH  byte-address width; the array holds 2^(ADDR_WIDTH-2) words
//   WAIT_CYCLES wait states before each access (0..15)
//
// Ports
//   clock       single clock, rising-edge active
//   reset       synchronous, active-high; aborts any outstanding access
//   do_dm_read  read request
//   do_dm_write write request
//   dm_address  byte address; word index = dm_address[ADDR_WIDTH-1:2]
//   dm_in       write data
//   dm_out      read data; holds the most recent completed read
//   dm_ready    one-cycle completion pulse
//   dm_busy     high while a transaction is outstanding (WAIT or RESP)
//   dm_error    one-cycle pulse after a rejected request
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  do_dm_read,
    input  logic                  do_dm_write,
    input  logic [ADDR_WIDTH-1:0] dm_address,
    input  logic [31:0]           dm_in,
    output logic [31:0]           dm_out,
    output logic                  dm_ready,
    output logic                  dm_busy,
    output logic                  dm_error
);

    localparam int         WORD_W    = ADDR_WIDTH - 2;
    localparam int         DEPTH     = 1 << WORD_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          wait_cnt;
    logic                accept;
    logic                reject;
    logic                access;

    logic                op_write;
    logic [WORD_W-1:0]   word_addr;
    logic [31:0]         wr_data;

    logic [31:0]         mem [0:DEPTH-1];

    logic                one_req;
    logic                both_req;
    logic                misaligned;
    logic                reject_req;

    // Request decode (combinational, only acted upon in IDLE)
    assign one_req  = do_dm_read ^ do_dm_write;
    assign both_req = do_dm_read & do_dm_write;

`ifdef DM_ALIGN_CHECK_EN
    assign misaligned = |dm_address[1:0];
`else
    // Byte-lane bits carry no meaning when alignment is not enforced.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^dm_address[1:0];
    assign misaligned       = 1'b0;
`endif

    assign reject_req = both_req | (one_req & misaligned);

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and control decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        access     = 1'b0;
        dm_busy    = 1'b0;
        case (state)
            IDLE: begin
                if (reject_req) begin
                    reject = 1'b1;
                end else if (one_req) begin
                    accept     = 1'b1;
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                dm_busy = 1'b1;
                // The edge that takes the counter from 1 to 0 also enters RESP.
                if (wait_cnt <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                dm_busy    = 1'b1;
                access     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Wait counter and registered status pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            dm_ready <= 1'b0;
            dm_error <= 1'b0;
        end else begin
            dm_ready <= access;
            dm_error <= reject;
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Request capture: frozen from acceptance until the next acceptance
    always_ff @(posedge clock) begin
        if (accept) begin
            op_write  <= do_dm_write;
            word_addr <= dm_address[ADDR_WIDTH-1:2];
            wr_data   <= dm_in;
        end
    end

    // Storage array: never reset; a reset on the commit edge aborts the write
    always_ff @(posedge clock) begin
        if (access && op_write && !reset) begin
            mem[word_addr] <= wr_data;
        end
    end

    // Read data register: updated only by a completing read
    always_ff @(posedge clock) begin
        if (reset) begin
            dm_out <= 32'h0;
        end else if (access && !op_write) begin
            dm_out <= mem[word_addr];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int AW = 12;
    localparam int W  = 2;
`ifdef DM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;

    // DUT with WAIT_CYCLES = 2
    logic          rd, wr;
    logic [AW-1:0] address;
    logic [31:0]   din, dout;
    logic          ready, busy, err;

    // DUT with WAIT_CYCLES = 0
    logic          zrd, zwr;
    logic [AW-1:0] zaddr;
    logic [31:0]   zdin, zdout;
    logic          zready, zbusy, zerr;

    int            vecs = 0;
    int            errs = 0;

    // Reference model: sparse word store plus the value dm_out must hold.
    bit [31:0]     model_mem [int];
    int            known [$];
    logic [31:0]   last_read;

    always #5 clock = ~clock;

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .do_dm_read (rd),
        .do_dm_write(wr),
        .dm_address (address),
        .dm_in      (din),
        .dm_out     (dout),
        .dm_ready   (ready),
        .dm_busy    (busy),
        .dm_error   (err)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
        .clock      (clock),
        .reset      (reset),
        .do_dm_read (zrd),
        .do_dm_write(zwr),
        .dm_address (zaddr),
        .dm_in      (zdin),
        .dm_out     (zdout),
        .dm_ready   (zready),
        .dm_busy    (zbusy),
        .dm_error   (zerr)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the WAIT_CYCLES=2 DUT, checked cycle by
    // cycle against the timing rules; optionally scribbles new requests on
    // the bus while the access is outstanding.
    task automatic txn(input bit rd_i, input bit wr_i, input logic [AW-1:0] addr,
                       input logic [31:0] data, input bit toggle);
        bit rej;
        int widx;
        rej  = (rd_i && wr_i) || ((rd_i ^ wr_i) && ALIGN && (addr[1:0] != 2'b00));
        widx = int'(addr >> 2);
        rd = rd_i; wr = wr_i; address = addr; din = data;
        tick();
        rd = 1'b0; wr = 1'b0; address = 12'($urandom); din = $urandom;
        if (rej) begin
            check("err_pulse", 32'(err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            check("err_ready", 32'(ready), 32'd0);
            tick();
            check("err_clear", 32'(err), 32'd0);
            check("err_idle", 32'(busy), 32'd0);
            check("err_dout", dout, last_read);
        end else begin
            for (int k = 0; k <= W; k++) begin
                check("busy", 32'(busy), 32'd1);
                check("ready_early", 32'(ready), 32'd0);
                if (toggle) begin
                    rd = 1'($urandom_range(0, 1)); wr = ~rd;
                    address = 12'($urandom); din = $urandom;
                end
                tick();
            end
            rd = 1'b0; wr = 1'b0;
            check("ready", 32'(ready), 32'd1);
            check("busy_done", 32'(busy), 32'd0);
            if (rd_i) begin
                if (model_mem.exists(widx)) last_read = model_mem[widx];
            end else begin
                if (!model_mem.exists(widx)) known.push_back(widx);
                model_mem[widx] = data;
            end
            check("dout", dout, last_read);
            tick();
            check("ready_pulse", 32'(ready), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        rd = 1'b0; wr = 1'b0; address = '0; din = '0;
        zrd = 1'b0; zwr = 1'b0; zaddr = '0; zdin = '0;
        last_read = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dout", dout, 32'h0);
        check("rst_z_dout", zdout, 32'h0);
        check("rst_z_busy", 32'(zbusy), 32'd0);
        reset = 1'b0;
        tick();

        // Basic write then read-after-write
        txn(1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 1'b0, 12'h010, 32'h0, 1'b0);
        check("raw_const", dout, 32'hDEADBEEF);

        // Simultaneous read+write is rejected and leaves memory untouched
        txn(1'b0, 1'b1, 12'h020, 32'hA5A50020, 1'b0);
        txn(1'b1, 1'b1, 12'h020, 32'hFFFFFFFF, 1'b0);
        txn(1'b1, 1'b0, 12'h020, 32'h0, 1'b0);
        check("both_prior", dout, 32'hA5A50020);

        // Bus activity during the access must not alter the latched request
        txn(1'b0, 1'b1, 12'h040, 32'h0BADF00D, 1'b1);
        txn(1'b1, 1'b0, 12'h040, 32'h0, 1'b1);
        check("toggle_const", dout, 32'h0BADF00D);

        // Reset in the middle of a write aborts it
        txn(1'b0, 1'b1, 12'h030, 32'h11111111, 1'b0);
        wr = 1'b1; address = 12'h030; din = 32'h12345678;
        tick();
        wr = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_read = 32'h0;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_dout", dout, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_no_ready", 32'(ready), 32'd0);
        end
        txn(1'b1, 1'b0, 12'h030, 32'h0, 1'b0);
        check("abort_old", dout, 32'h11111111);

        // Reset dominates a request sampled on the same edge
        reset = 1'b1; rd = 1'b1; address = 12'h010;
        tick();
        reset = 1'b0; rd = 1'b0;
        check("rst_dom_busy", 32'(busy), 32'd0);
        tick();
        check("rst_dom_ready", 32'(ready), 32'd0);
        check("rst_dom_busy2", 32'(busy), 32'd0);
        last_read = 32'h0;

        // Misaligned write: rejected with alignment checking, else lands on word 4
        txn(1'b0, 1'b1, 12'h013, 32'hCAFE0013, 1'b0);
        txn(1'b1, 1'b0, 12'h010, 32'h0, 1'b0);
        check("align_word", dout, ALIGN ? 32'hDEADBEEF : 32'hCAFE0013);

        // Zero-wait DUT: single-cycle latency and back-to-back held reads
        zwr = 1'b1; zaddr = 12'h008; zdin = 32'h5555AAAA;
        tick();
        zwr = 1'b0;
        check("z_w_busy", 32'(zbusy), 32'd1);
        check("z_w_ready0", 32'(zready), 32'd0);
        tick();
        check("z_w_ready", 32'(zready), 32'd1);
        check("z_w_idle", 32'(zbusy), 32'd0);
        tick();
        check("z_w_pulse", 32'(zready), 32'd0);
        zrd = 1'b1; zaddr = 12'h008;
        tick();
        check("z_r1_busy", 32'(zbusy), 32'd1);
        check("z_r1_ready0", 32'(zready), 32'd0);
        tick();
        check("z_r1_ready", 32'(zready), 32'd1);
        check("z_r1_dout", zdout, 32'h5555AAAA);
        tick();
        check("z_r2_ready0", 32'(zready), 32'd0);
        check("z_r2_busy", 32'(zbusy), 32'd1);
        tick();
        zrd = 1'b0;
        check("z_r2_ready", 32'(zready), 32'd1);
        check("z_r2_dout", zdout, 32'h5555AAAA);
        tick();
        check("z_r2_pulse", 32'(zready), 32'd0);
        check("z_idle", 32'(zbusy), 32'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            int            kind;
            logic [AW-1:0] a;
            kind = int'($urandom_range(0, 9));
            if (kind < 4 || known.size() == 0) begin
                a = 12'($urandom);
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                txn(1'b0, 1'b1, a, $urandom, 1'($urandom_range(0, 1)));
            end else if (kind < 9) begin
                a = 12'(known[$urandom_range(0, known.size() - 1)] * 4);
                if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
                txn(1'b1, 1'b0, a, $urandom, 1'($urandom_range(0, 1)));
            end else begin
                txn(1'b1, 1'b1, 12'($urandom), $urandom, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
